conv_sched: RTL and testbench

- Job controller for the 5x5 binary convolution engine and its sliding-window front end.
- Accepts one command: layer select plus kernel count. For each kernel it:
  - streams the 25 sign bits from weight memory into the engine;
  - launches the window generator;
  - tags every valid convolution output with (kernel, row, col);
  - waits for the engine's done, then moves to the next kernel.
- Sits between the top-level layer sequencer and the conv/window pair.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_tag_cnt.sv | 62 ++++++
 rtl/conv_sched.sv | 165 ++++++++++++++++
 tb/tb_conv_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution job controller: FSM states, layer geometry
// and expected output-beat counts.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WDLY,
    ST_RUN,
    ST_GAP
  } state_e;

  localparam int KSIDE    = 5;
  localparam int KK       = KSIDE * KSIDE;
  localparam int NI_L0    = 28;
  localparam int NI_L1    = 12;
  localparam int BEATS_L0 = 576;
  localparam int BEATS_L1 = 64;

  // Last valid output column (Ni-K) for the selected layer.
  function automatic logic [4:0] col_last(input logic layer);
    return layer ? 5'(NI_L1 - KSIDE) : 5'(NI_L0 - KSIDE);
  endfunction

  function automatic logic [10:0] exp_beats(input logic layer);
    return layer ? 11'(BEATS_L1) : 11'(BEATS_L0);
  endfunction

endpackage

// File: rtl/conv_tag_cnt.sv
// Row/column tag counters for engine output beats, plus a sticky check that the
// number of beats in a kernel job matches the layer's expected count.
module conv_tag_cnt
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       layer_i,
  input  logic       beat_i,
  input  logic       check_i,
  input  logic       clr_i,
  output logic [4:0] row_o,
  output logic [4:0] col_o,
  output logic       err_o
);

  logic [4:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [10:0] beats_q, beats_d, beats_inc;
  logic        err_q;

  // A beat arriving with the check still counts toward the compared total.
  assign beats_inc = beats_q + {10'd0, beat_i};

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    beats_d = beats_inc;
    if (beat_i) begin
      if (col_q == col_last(layer_i)) begin
        col_d = '0;
        row_d = row_q + 5'd1;
      end else begin
        col_d = col_q + 5'd1;
      end
    end
    if (clr_i) begin
      row_d   = '0;
      col_d   = '0;
      beats_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      beats_q <= '0;
      err_q   <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      beats_q <= beats_d;
      if (check_i && (beats_inc != exp_beats(layer_i))) err_q <= 1'b1;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;
  assign err_o = err_q;

endmodule

// File: rtl/conv_sched.sv
// Job controller for the 5x5 binary convolution engine: weight streaming, window launch,
// output tagging. Define CONV_SCHED_WDOG_EN to add the RUN-phase watchdog (err_timeout).
module conv_sched
  import conv_pkg::*;
#(
  parameter int K       = 5,
  parameter int KW      = 6,
  parameter int AW      = 12,
  parameter int WIN_DLY = 2,
  parameter int GAP_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_layer,
  input  logic [KW-1:0] cmd_nkern,
  output logic          wmem_rd,
  output logic [AW-1:0] wmem_addr,
  input  logic          wmem_data,
  output logic          conv_start,
  output logic          conv_state,
  output logic          conv_weight,
  output logic          conv_weight_en,
  output logic          win_start,
  input  logic          conv_ovalid,
  input  logic          conv_done,
  output logic          tag_valid,
  output logic [KW-1:0] tag_kidx,
  output logic [4:0]    tag_row,
  output logic [4:0]    tag_col,
  output logic          busy,
  output logic          job_done,
  output logic          err_count
`ifdef CONV_SCHED_WDOG_EN
  ,
  output logic          err_timeout
`endif
);

  localparam int NW = K * K;

  state_e        state_q;
  logic [7:0]    cnt_q;
  logic [KW-1:0] kidx_q, nkern_q;
  logic          layer_q;
  logic [AW-1:0] base_q;
  logic          job_done_q;
  logic          in_run, wd_fire, leave_run;

`ifdef CONV_SCHED_WDOG_EN
  logic [11:0] wd_q;
  logic        err_to_q;
  assign wd_fire     = in_run && (wd_q == 12'd2047) && !conv_done;
  assign err_timeout = err_to_q;
`else
  assign wd_fire = 1'b0;
`endif

  assign in_run    = (state_q == ST_RUN);
  assign leave_run = in_run && (conv_done || wd_fire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      kidx_q     <= '0;
      nkern_q    <= '0;
      layer_q    <= 1'b0;
      base_q     <= '0;
      job_done_q <= 1'b0;
`ifdef CONV_SCHED_WDOG_EN
      wd_q       <= '0;
      err_to_q   <= 1'b0;
`endif
    end else begin
      job_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && (cmd_nkern != '0)) begin
            layer_q <= cmd_layer;
            nkern_q <= cmd_nkern;
            kidx_q  <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cnt_q == 8'(NW)) begin
            cnt_q   <= '0;
            state_q <= ST_WDLY;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_WDLY: begin
          if (cnt_q == 8'(WIN_DLY - 1)) begin
            cnt_q   <= '0;
            state_q <= ST_RUN;
`ifdef CONV_SCHED_WDOG_EN
            wd_q    <= '0;
`endif
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_RUN: begin
`ifdef CONV_SCHED_WDOG_EN
          wd_q <= wd_q + 12'd1;
          if (wd_fire) err_to_q <= 1'b1;
`endif
          if (leave_run) begin
            cnt_q   <= '0;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_q == 8'(GAP_CYC - 1)) begin
            cnt_q <= '0;
            if (kidx_q == nkern_q - KW'(1)) begin
              job_done_q <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              kidx_q  <= kidx_q + KW'(1);
              base_q  <= base_q + AW'(NW);
              state_q <= ST_LOAD;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Weight bit i is read in LOAD cycle i and forwarded to the engine one cycle later.
  assign wmem_rd        = (state_q == ST_LOAD) && (cnt_q < 8'(NW));
  assign wmem_addr      = wmem_rd ? (base_q + AW'(cnt_q)) : '0;
  assign conv_weight_en = (state_q == ST_LOAD) && (cnt_q != '0);
  assign conv_weight    = conv_weight_en & wmem_data;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign conv_start = (state_q == ST_LOAD) || (state_q == ST_WDLY) || in_run;
  assign conv_state = busy & layer_q;
  assign win_start  = (state_q == ST_WDLY) && (cnt_q == 8'(WIN_DLY - 1));
  assign tag_valid  = in_run & conv_ovalid;
  assign tag_kidx   = kidx_q;
  assign job_done   = job_done_q;

  conv_tag_cnt u_tag_cnt (
    .clk     (clk),
    .rst     (rst),
    .layer_i (layer_q),
    .beat_i  (tag_valid),
    .check_i (in_run & conv_done),
    .clr_i   (leave_run),
    .row_o   (tag_row),
    .col_o   (tag_col),
    .err_o   (err_count)
  );

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched: timeline reference model compared every cycle,
// plus directed literal checks on load order, tag ranges, error flags and mid-job reset.
module tb_conv_sched;

  localparam int GAP = 2;

  logic        clk, rst, cmd_valid, cmd_ready, cmd_layer;
  logic [5:0]  cmd_nkern;
  logic        wmem_rd, wmem_data;
  logic [11:0] wmem_addr;
  logic        conv_start, conv_state, conv_weight, conv_weight_en, win_start;
  logic        conv_ovalid, conv_done, tag_valid, busy, job_done, err_count;
  logic [5:0]  tag_kidx;
  logic [4:0]  tag_row, tag_col;
  logic        act_to;
`ifdef CONV_SCHED_WDOG_EN
  logic        err_timeout;
  assign act_to = err_timeout;
`else
  assign act_to = 1'b0;
`endif

  conv_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_layer(cmd_layer), .cmd_nkern(cmd_nkern), .wmem_rd(wmem_rd),
    .wmem_addr(wmem_addr), .wmem_data(wmem_data), .conv_start(conv_start),
    .conv_state(conv_state), .conv_weight(conv_weight), .conv_weight_en(conv_weight_en),
    .win_start(win_start), .conv_ovalid(conv_ovalid), .conv_done(conv_done),
    .tag_valid(tag_valid), .tag_kidx(tag_kidx), .tag_row(tag_row), .tag_col(tag_col),
    .busy(busy), .job_done(job_done), .err_count(err_count)
`ifdef CONV_SCHED_WDOG_EN
    , .err_timeout(err_timeout)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit wmem [0:4095];
  int n_chk, n_pass;

  // reference model
  int cyc, m_kstart, m_done_at, m_jd_at, m_beats, m_k, m_nk, rel, mw;
  bit m_busy, m_layer, m_err, m_to, cmp_on, ph_run, ph_gap_last;
  logic [40:0] act_v, exp_v;
  logic        e_rd, e_en, e_w, e_win, e_tv, e_cs;
  logic [11:0] e_addr;
  logic [4:0]  e_row, e_col;

  // monitor for directed checks
  int we_cnt, win_off, rise_cyc, min_gap, gaplen, jd_cnt, last_row, last_col, last_k;
  int tagcnt [64];
  int load_base [$];
  logic [31:0] wbits;
  bit prev_rd, prev_cs, st_or, run_k1;

  // engine model
  int q_nb [$];
  int q_md [$];
  bit eng_layer, eng_abort;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic clear_mon();
    we_cnt = 0; wbits = '0; win_off = -1; rise_cyc = -1; min_gap = 1000; gaplen = 0;
    jd_cnt = 0; last_row = -1; last_col = -1; last_k = -1; st_or = 0; run_k1 = 0;
    load_base.delete();
    for (int i = 0; i < 64; i++) tagcnt[i] = 0;
  endtask

  // Weight memory: one-cycle read latency.
  initial begin
    bit pend;
    logic [11:0] pa;
    wmem_data = 1'b0;
    forever begin
      @(negedge clk);
      pend = (wmem_rd === 1'b1);
      pa = wmem_addr;
      @(posedge clk);
      #1 wmem_data = pend ? wmem[pa] : 1'b0;
    end
  end

  // Engine: after win_start, emits rows of Ni-4 valid beats out of every Ni cycles.
  // Mode 0: done one cycle after the last beat; 1: done with the last beat; 2: no done.
  task automatic run_eng();
    int nb, md, ni, w, emitted, p;
    nb = (q_nb.size() > 0) ? q_nb.pop_front() : 0;
    md = (q_md.size() > 0) ? q_md.pop_front() : 0;
    ni = eng_layer ? 12 : 28;
    w = ni - 4; emitted = 0; p = 0;
    while (emitted < nb) begin
      @(posedge clk); #2;
      if (eng_abort) begin conv_ovalid = 1'b0; conv_done = 1'b0; return; end
      conv_ovalid = ((p % ni) < w);
      if (conv_ovalid) emitted++;
      conv_done = (md == 1) && conv_ovalid && (emitted == nb);
      p++;
    end
    if (md == 0) begin
      @(posedge clk); #2;
      conv_ovalid = 1'b0;
      conv_done = !eng_abort;
    end
    @(posedge clk); #2;
    conv_ovalid = 1'b0; conv_done = 1'b0;
  endtask

  initial begin
    conv_ovalid = 1'b0; conv_done = 1'b0;
    forever begin
      @(negedge clk);
      if (win_start === 1'b1) run_eng();
    end
  end

  // Per-cycle compare against the timeline model, then monitor and model advance.
  initial begin
    cyc = 0; m_busy = 0; m_err = 0; m_to = 0; m_jd_at = -1; cmp_on = 0;
    m_kstart = 0; m_done_at = -1; m_beats = 0; m_k = 0; m_nk = 0; m_layer = 0;
    forever begin
      @(negedge clk);
      mw = m_layer ? 8 : 24;
      e_cs = 0; e_rd = 0; e_addr = '0; e_en = 0; e_w = 0; e_win = 0; e_tv = 0;
      e_row = '0; e_col = '0; ph_run = 0; ph_gap_last = 0;
      if (m_busy) begin
        rel = cyc - m_kstart;
        if (m_done_at < 0) begin
          e_cs = 1;
          if (rel <= 25) begin
            e_rd = (rel <= 24);
            if (e_rd) e_addr = 12'(m_k * 25 + rel);
            e_en = (rel >= 1);
            if (e_en) e_w = wmem[m_k * 25 + rel - 1];
          end else if (rel == 27) begin
            e_win = 1;
          end else if (rel >= 28) begin
            ph_run = 1;
            e_tv = (conv_ovalid === 1'b1);
            if (e_tv) begin
              e_row = 5'(m_beats / mw);
              e_col = 5'(m_beats % mw);
            end
          end
        end else begin
          ph_gap_last = ((cyc - m_done_at) == GAP);
        end
      end
      exp_v = {!m_busy, m_busy, e_cs, m_busy & m_layer, e_rd, e_addr, e_en, e_w, e_win, e_tv,
               (m_busy ? 6'(m_k) : 6'd0), e_row, e_col, (cyc == m_jd_at), m_err, m_to, 1'b0};
      act_v = {cmd_ready, busy, conv_start, conv_state, wmem_rd, (e_rd ? wmem_addr : 12'd0),
               conv_weight_en, (e_en ? conv_weight : 1'b0), win_start, tag_valid,
               (m_busy ? tag_kidx : 6'd0), (e_tv ? tag_row : 5'd0), (e_tv ? tag_col : 5'd0),
               job_done, err_count, act_to, 1'b0};
      if (cmp_on) begin
        n_chk++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act_v, exp_v);
        if (conv_weight_en) begin
          if (we_cnt < 32) wbits[we_cnt] = conv_weight;
          we_cnt++;
        end
        if (conv_start && !prev_cs) begin
          if (rise_cyc < 0) rise_cyc = cyc;
          if (gaplen > 0 && gaplen < min_gap) min_gap = gaplen;
          gaplen = 0;
        end
        if (busy && !conv_start) gaplen++;
        else if (!busy) gaplen = 0;
        if (win_start && win_off < 0 && rise_cyc >= 0) win_off = cyc - rise_cyc;
        if (wmem_rd && !prev_rd) load_base.push_back(int'(wmem_addr));
        if (busy) st_or = st_or | conv_state;
        if (tag_valid) begin
          tagcnt[tag_kidx]++;
          last_row = int'(tag_row); last_col = int'(tag_col); last_k = int'(tag_kidx);
          if (tag_kidx == 6'd1) run_k1 = 1;
        end
        if (job_done) jd_cnt++;
        prev_rd = wmem_rd; prev_cs = conv_start;
      end
      if (!m_busy) begin
        if (cmd_valid === 1'b1 && cmd_nkern != 6'd0) begin
          m_busy = 1; m_layer = cmd_layer; m_nk = int'(cmd_nkern); m_k = 0;
          m_kstart = cyc + 1; m_done_at = -1; m_beats = 0;
        end
      end else if (ph_run) begin
        if (conv_ovalid === 1'b1) m_beats++;
        if (conv_done === 1'b1) begin
          if (m_beats != mw * mw) m_err = 1;
          m_done_at = cyc;
        end
`ifdef CONV_SCHED_WDOG_EN
        else if ((cyc - (m_kstart + 28)) == 2047) begin
          m_to = 1;
          m_done_at = cyc;
        end
`endif
      end else if (ph_gap_last) begin
        if (m_k == m_nk - 1) begin
          m_busy = 0;
          m_jd_at = cyc + 1;
        end else begin
          m_k++; m_kstart = cyc + 1; m_done_at = -1; m_beats = 0;
        end
      end
      if (rst === 1'b1) begin
        m_busy = 0; m_err = 0; m_to = 0; m_jd_at = -1; cmp_on = 1;
        prev_rd = 0; prev_cs = 0;
      end
      cyc++;
    end
  end

  task automatic issue(input bit l, input int nk);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_layer = l; cmd_nkern = 6'(nk); eng_layer = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_job(input int budget, input string nm);
    int i;
    i = 0;
    while (jd_cnt == 0 && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    chk(nm, (jd_cnt > 0) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_layer = 1'b0; cmd_nkern = '0;
    eng_abort = 0; eng_layer = 0;
    for (int a = 0; a < 4096; a++) wmem[a] = (a < 25) ? (a % 2 == 0) : 1'($urandom_range(0, 1));
    clear_mon();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_conv_start", conv_start, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_tag_valid", tag_valid, 0);

    // nkern = 0 is ignored
    issue(0, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("nk0_busy", busy, 0);
    chk("nk0_job_done", jd_cnt, 0);
    chk("nk0_weights", we_cnt, 0);

    // layer 0, one kernel, 576 beats
    clear_mon();
    q_nb.push_back(576); q_md.push_back(0);
    issue(0, 1);
    wait_job(2000, "t1_job_done");
    chk("t1_weight_en_cycles", we_cnt, 25);
    chk("t1_weight_bits", int'(wbits), 32'h1555555);
    chk("t1_win_offset", win_off, 27);
    chk("t1_conv_state", int'(st_or), 0);
    chk("t1_tag_count", tagcnt[0], 576);
    chk("t1_last_row", last_row, 23);
    chk("t1_last_col", last_col, 23);
    chk("t1_job_done_pulses", jd_cnt, 1);
    chk("t1_err_count", err_count, 0);

    // layer 1, three kernels; kernel 1 ends with beat and done together
    clear_mon();
    q_nb = '{64, 64, 64}; q_md = '{0, 1, 0};
    issue(1, 3);
    wait_job(2000, "t2_job_done");
    chk("t2_load_phases", load_base.size(), 3);
    if (load_base.size() == 3) begin
      chk("t2_base0", load_base[0], 0);
      chk("t2_base1", load_base[1], 25);
      chk("t2_base2", load_base[2], 50);
    end
    chk("t2_min_start_gap", min_gap, 2);
    chk("t2_conv_state", int'(st_or), 1);
    chk("t2_tags_k0", tagcnt[0], 64);
    chk("t2_tags_k1", tagcnt[1], 64);
    chk("t2_tags_k2", tagcnt[2], 64);
    chk("t2_last_kidx", last_k, 2);
    chk("t2_last_row", last_row, 7);
    chk("t2_last_col", last_col, 7);
    chk("t2_err_count", err_count, 0);

    // short kernel: 575 beats flags the error, next kernel still runs
    clear_mon();
    q_nb = '{575, 576}; q_md = '{0, 0};
    issue(0, 2);
    wait_job(4000, "t3_job_done");
    chk("t3_err_count", err_count, 1);
    chk("t3_tags_k1", tagcnt[1], 576);
    clear_mon();
    q_nb = '{64}; q_md = '{0};
    issue(1, 1);
    wait_job(1000, "t3b_job_done");
    chk("t3_err_sticky", err_count, 1);

    // reset during RUN of kernel 1 of 3
    clear_mon();
    q_nb = '{64, 64, 64}; q_md = '{0, 0, 0};
    issue(1, 3);
    i = 0;
    while (!run_k1 && i < 1000) begin
      @(negedge clk); #1;
      i++;
    end
    chk("t4_reached_k1_run", int'(run_k1), 1);
    @(posedge clk); #1;
    rst = 1'b1; eng_abort = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("t4_conv_start", conv_start, 0);
    chk("t4_busy", busy, 0);
    chk("t4_cmd_ready", cmd_ready, 1);
    chk("t4_err_cleared", err_count, 0);
    repeat (3) @(posedge clk);
    #1;
    q_nb.delete(); q_md.delete(); eng_abort = 0;
    clear_mon();
    q_nb = '{64}; q_md = '{0};
    issue(1, 1);
    wait_job(1000, "t4_job_done");
    chk("t4_restart_base", (load_base.size() > 0) ? load_base[0] : -1, 0);
    chk("t4_restart_tags_k0", tagcnt[0], 64);

`ifdef CONV_SCHED_WDOG_EN
    // no done on kernel 0: watchdog forces GAP and kernel 1 proceeds
    clear_mon();
    q_nb = '{64, 64}; q_md = '{2, 0};
    issue(1, 2);
    wait_job(6000, "t5_job_done");
    chk("t5_err_timeout", err_timeout, 1);
    chk("t5_tags_k1", tagcnt[1], 64);
    chk("t5_err_count", err_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
